// File: rtl/alu_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the execute-stage ALU:
//   - alu_ctr_e : 4-bit ALU control codes produced by the decoder
//   - ALUOP_*   : 2-bit ALUOp encodings coming from the main decoder
//   - state_e   : sequencing states of the execute unit
//   - base_ctr  : funct3 -> control code mapping shared by R- and I-type
// ---------------------------------------------------------------------------
package alu_exec_pkg;

   typedef enum logic [3:0] {
      CTR_AND  = 4'b0000,
      CTR_OR   = 4'b0001,
      CTR_ADD  = 4'b0010,
      CTR_SLL  = 4'b0011,
      CTR_SRL  = 4'b0100,
      CTR_SRA  = 4'b0101,
      CTR_SUB  = 4'b0110,
      CTR_SLT  = 4'b0111,
      CTR_XOR  = 4'b1000,
      CTR_SLTU = 4'b1001,
      CTR_MUL  = 4'b1010,
      CTR_DIV  = 4'b1011,
      CTR_DIVU = 4'b1100,
      CTR_REM  = 4'b1101,
      CTR_REMU = 4'b1110
   } alu_ctr_e;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10
   } state_e;

   // alt selects SUB for funct3=000 and SRA for funct3=101; the caller
   // decides whether instruction bit 30 is meaningful for that format.
   function automatic alu_ctr_e base_ctr(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? CTR_SUB : CTR_ADD;
         3'b001:  return CTR_SLL;
         3'b010:  return CTR_SLT;
         3'b011:  return CTR_SLTU;
         3'b100:  return CTR_XOR;
         3'b101:  return alt ? CTR_SRA : CTR_SRL;
         3'b110:  return CTR_OR;
         default: return CTR_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative MUL / DIV / DIVU / REM / REMU engine, one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands (op, op_a, op_b) this edge
//   abort      : drop the operation in flight
//   done       : final iteration happens on the coming edge; res is valid now
//   res        : sign-corrected result of the final iteration
// One shift register (sh_reg) is the multiplier for MUL and the dividend /
// quotient for division; acc_reg is the product or the partial remainder.
// Division works on magnitudes; signs are applied when the result is formed.
// ---------------------------------------------------------------------------
module alu_muldiv_iter
   import alu_exec_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  alu_ctr_e        op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] res
);

   localparam logic [SHW-1:0] LAST = {SHW{1'b1}};   // index of the final iteration

   logic            busy_reg, is_mul_reg, want_rem_reg, neg_q_reg, neg_r_reg;
   logic [SHW-1:0]  cnt_reg;
   logic [XLEN-1:0] sh_reg, opnd_reg;
   logic [XLEN:0]   acc_reg;

   logic            signed_op;
   logic [XLEN-1:0] mag_a, mag_b, sh_step;
   logic [XLEN:0]   acc_step, rem_shift, rem_diff;

   assign signed_op = (op == CTR_DIV) || (op == CTR_REM);
   assign mag_a     = (signed_op && op_a[XLEN-1]) ? -op_a : op_a;
   assign mag_b     = (signed_op && op_b[XLEN-1]) ? -op_b : op_b;

   // One iteration of the selected algorithm, computed from the current state.
   always_comb begin
      rem_shift = {acc_reg[XLEN-1:0], sh_reg[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, opnd_reg};
      if (is_mul_reg) begin
         acc_step = sh_reg[0] ? {1'b0, acc_reg[XLEN-1:0] + opnd_reg} : acc_reg;
         sh_step  = sh_reg >> 1;
      end else if (!rem_diff[XLEN]) begin
         acc_step = rem_diff;
         sh_step  = {sh_reg[XLEN-2:0], 1'b1};
      end else begin
         acc_step = rem_shift;
         sh_step  = {sh_reg[XLEN-2:0], 1'b0};
      end
   end

   assign done = busy_reg && (cnt_reg == LAST);

   // Result is formed from the final iteration's values so the caller can
   // register it on the same edge that performs that iteration.
   always_comb begin
      if (is_mul_reg)
         res = acc_step[XLEN-1:0];
      else if (want_rem_reg)
         res = neg_r_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      else
         res = neg_q_reg ? -sh_step : sh_step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg     <= 1'b0;
         is_mul_reg   <= 1'b0;
         want_rem_reg <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         cnt_reg      <= '0;
         sh_reg       <= '0;
         opnd_reg     <= '0;
         acc_reg      <= '0;
      end else if (abort) begin
         busy_reg <= 1'b0;
      end else if (start) begin
         busy_reg     <= 1'b1;
         cnt_reg      <= '0;
         acc_reg      <= '0;
         is_mul_reg   <= (op == CTR_MUL);
         want_rem_reg <= (op == CTR_REM) || (op == CTR_REMU);
         neg_q_reg    <= signed_op && (op_a[XLEN-1] ^ op_b[XLEN-1]);
         neg_r_reg    <= signed_op && op_a[XLEN-1];
         if (op == CTR_MUL) begin
            sh_reg   <= op_b;
            opnd_reg <= op_a;
         end else begin
            sh_reg   <= mag_a;
            opnd_reg <= mag_b;
         end
      end else if (busy_reg) begin
         acc_reg <= acc_step;
         sh_reg  <= sh_step;
         if (is_mul_reg)
            opnd_reg <= opnd_reg << 1;
         cnt_reg <= cnt_reg + SHW'(1);
         if (cnt_reg == LAST)
            busy_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU: ALUOp/funct decode, single-cycle RV32I datapath and an
// iterative RV32M engine behind valid/ready handshakes.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : abort any accepted / in-flight operation
//   in_valid / in_ready  : operation handshake
//   alu_op, funct3,
//   funct7_b5, funct7_b0 : instruction decode fields
//   op_a, op_b           : operands (op_b may be an immediate)
//   out_valid / out_ready: result handshake
//   result, zero, illegal: registered result, result==0, bad encoding
// ---------------------------------------------------------------------------
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_b5,
   input  logic            funct7_b0,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_reg, state_next;
   logic            out_valid_reg, zero_reg, illegal_reg;
   logic [XLEN-1:0] result_reg;

   alu_ctr_e        ctr;
   logic            bad, accept, go_iter, is_div_op, signed_div, div_zero, div_ovf;
   logic            eng_start, eng_done;
   logic [XLEN-1:0] quick_res, fast_val, eng_res;
   logic [SHW-1:0]  shamt;

   // ---------------- decode ----------------
   always_comb begin
      ctr = CTR_ADD;
      bad = 1'b0;
      case (alu_op)
         ALUOP_MEM: ctr = CTR_ADD;
         ALUOP_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: ctr = CTR_SUB;
               3'b100, 3'b101: ctr = CTR_SLT;
               3'b110, 3'b111: ctr = CTR_SLTU;
               default:        bad = 1'b1;
            endcase
         end
         ALUOP_RTYPE: begin
            if (funct7_b0) begin
               case (funct3)
                  3'b000:  ctr = CTR_MUL;
                  3'b100:  ctr = CTR_DIV;
                  3'b101:  ctr = CTR_DIVU;
                  3'b110:  ctr = CTR_REM;
                  3'b111:  ctr = CTR_REMU;
                  default: bad = 1'b1;          // high-half multiplies decode as illegal
               endcase
            end else begin
               ctr = base_ctr(funct3, funct7_b5);
            end
         end
         // I-type: bit 30 is immediate data for ADDI, only selects SRAI.
         default: ctr = base_ctr(funct3, (funct3 == 3'b101) && funct7_b5);
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   assign shamt      = op_b[SHW-1:0];
   assign div_zero   = (op_b == '0);
   assign div_ovf    = (op_a == MIN_VAL) && (op_b == '1);
   assign is_div_op  = (ctr == CTR_DIV) || (ctr == CTR_DIVU) || (ctr == CTR_REM) || (ctr == CTR_REMU);
   assign signed_div = (ctr == CTR_DIV) || (ctr == CTR_REM);

   // Divide-by-zero and signed overflow have fixed answers and skip iteration.
   assign go_iter = !bad && ((ctr == CTR_MUL) ||
                             (is_div_op && !div_zero && !(signed_div && div_ovf)));

   always_comb begin
      quick_res = '0;
      case (ctr)
         CTR_ADD:  quick_res = op_a + op_b;
         CTR_SUB:  quick_res = op_a - op_b;
         CTR_AND:  quick_res = op_a & op_b;
         CTR_OR:   quick_res = op_a | op_b;
         CTR_XOR:  quick_res = op_a ^ op_b;
         CTR_SLL:  quick_res = op_a << shamt;
         CTR_SRL:  quick_res = op_a >> shamt;
         CTR_SRA:  quick_res = $signed(op_a) >>> shamt;
         CTR_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         CTR_SLTU: quick_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         CTR_DIV:  quick_res = div_zero ? '1 : MIN_VAL;
         CTR_DIVU: quick_res = '1;
         CTR_REM:  quick_res = div_zero ? op_a : '0;
         CTR_REMU: quick_res = op_a;
         default:  quick_res = '0;
      endcase
   end

   assign fast_val  = bad ? '0 : quick_res;
   assign accept    = in_valid && in_ready && !flush;
   assign eng_start = accept && go_iter;

   alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (eng_start),
      .abort (flush),
      .op    (ctr),
      .op_a  (op_a),
      .op_b  (op_b),
      .done  (eng_done),
      .res   (eng_res)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (eng_start) state_next = (ctr == CTR_MUL) ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (eng_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
   end

   // ---------------- result register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         zero_reg      <= 1'b1;
         illegal_reg   <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else begin
         if (out_valid_reg && out_ready)
            out_valid_reg <= 1'b0;
         // Completion and acceptance are exclusive: accept needs ST_IDLE.
         if (eng_done) begin
            result_reg    <= eng_res;
            zero_reg      <= (eng_res == '0);
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
         end else if (accept && !go_iter) begin
            result_reg    <= fast_val;
            zero_reg      <= (fast_val == '0);
            illegal_reg   <= bad;
            out_valid_reg <= 1'b1;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign zero      = zero_reg;
   assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [1:0]  alu_op = 2'b00;
   logic [2:0]  funct3 = 3'b000;
   logic        funct7_b5 = 1'b0, funct7_b0 = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        in_ready, out_valid, zero, illegal;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .funct7_b0 (funct7_b0),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the ISA rules: result, illegal flag and
   // the cycle (relative to accept) at which the result is first sampled.
   function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic b5, input logic b0,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      int sa, sb;
      logic [4:0] sh;
      logic ovf;
      sa = a; sb = b; sh = b[4:0];
      r = '0; ill = 1'b0; lat = 1;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (op == 2'b00) begin
         r = a + b;
      end else if (op == 2'b01) begin
         if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
         else if (f3 <= 3'b001)            r = a - b;
         else if (f3 <= 3'b101)            r = (sa < sb) ? 32'd1 : 32'd0;
         else                              r = (a < b) ? 32'd1 : 32'd0;
      end else if (op == 2'b10 && b0) begin
         case (f3)
            3'd0: begin r = a * b; lat = 33; end
            3'd4: if (b == 0) r = 32'hFFFF_FFFF;
                  else if (ovf) r = 32'h8000_0000;
                  else begin r = 32'(sa / sb); lat = 33; end
            3'd5: if (b == 0) r = 32'hFFFF_FFFF;
                  else begin r = a / b; lat = 33; end
            3'd6: if (b == 0) r = a;
                  else if (ovf) r = 32'd0;
                  else begin r = 32'(sa % sb); lat = 33; end
            3'd7: if (b == 0) r = a;
                  else begin r = a % b; lat = 33; end
            default: ill = 1'b1;
         endcase
      end else begin
         case (f3)
            3'd0: r = (op == 2'b10 && b5) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = b5 ? 32'(sa >>> sh) : a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
   endfunction

   task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                        input logic b0, input logic [31:0] a, input logic [31:0] b);
      alu_op = op; funct3 = f3; funct7_b5 = b5; funct7_b0 = b0; op_a = a; op_b = b;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                         input logic b0, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      logic [31:0] er;
      logic        ei, leak;
      int          el, lat;
      model(op, f3, b5, b0, a, b, er, ei, el);
      @(negedge clk);
      chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      drive(op, f3, b5, b0, a, b);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat  = 1;
      leak = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) leak = 1'b1;
         @(posedge clk);
         #1 lat++;
      end
      $display("op=%b f3=%b b5=%b b0=%b a=%h b=%h -> result=%h zero=%b illegal=%b lat=%0d [%s]",
               op, f3, b5, b0, a, b, result, zero, illegal, lat, tag);
      chk({tag, "/latency"}, 32'(lat), 32'(el));
      chk({tag, "/result"}, result, er);
      chk({tag, "/zero"}, 32'(zero), 32'(er == 0));
      chk({tag, "/illegal"}, 32'(illegal), 32'(ei));
      chk({tag, "/busy_ready"}, 32'(leak), 32'd0);
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, "/retired"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [2:0]  rf3;
      logic        rb5, rb0, seen;
      logic [31:0] ra, rb, held;

      // ---- reset state ----
      #12;
      chk("reset/out_valid", 32'(out_valid), 32'd0);
      chk("reset/result", result, 32'd0);
      chk("reset/zero", 32'(zero), 32'd1);
      chk("reset/illegal", 32'(illegal), 32'd0);
      chk("reset/in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;

      // ---- directed base / branch ----
      run_op(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, "sub");
      run_op(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24, "sra");
      run_op(2'b11, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, "addi_b5");
      run_op(2'b11, 3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'h4, "srai");
      run_op(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, "beq");
      run_op(2'b01, 3'b110, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, "bltu");
      run_op(2'b01, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, "blt");
      run_op(2'b01, 3'b010, 1'b0, 1'b0, 32'd3, 32'd4, "br_illegal");
      run_op(2'b10, 3'b001, 1'b0, 1'b1, 32'd3, 32'd4, "mulh_illegal");

      // ---- directed M-extension ----
      run_op(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, "mul");
      run_op(2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div");
      run_op(2'b10, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "rem");
      run_op(2'b10, 3'b101, 1'b0, 1'b1, 32'd7, 32'd0, "divu_by0");
      run_op(2'b10, 3'b110, 1'b0, 1'b1, 32'd7, 32'd0, "rem_by0");
      run_op(2'b10, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'b10, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(2'b10, 3'b111, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd5, "remu");

      // ---- randomized ----
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         rf3 = 3'($urandom_range(0, 7));
         rb5 = 1'($urandom_range(0, 1));
         rb0 = (rop == 2'b10) ? 1'($urandom_range(0, 1)) : 1'b0;
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 40));
            default: ;
         endcase
         run_op(rop, rf3, rb5, rb0, ra, rb, "rand");
      end

      // ---- backpressure, then retire + accept in the same edge ----
      @(negedge clk);
      drive(2'b10, 3'b100, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F);
      in_valid = 1'b1;
      @(posedge clk);
      #1 held = 32'h1234_5678 ^ 32'h0F0F_0F0F;
      @(negedge clk) drive(2'b10, 3'b111, 1'b0, 1'b0, 32'h00FF_00FF, 32'h0F0F_0F0F);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         $display("stall cycle %0d: out_valid=%b in_ready=%b result=%h", k, out_valid, in_ready, result);
         chk("stall/result", result, held);
         chk("stall/in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b0;
      $display("retire+accept: out_valid=%b result=%h", out_valid, result);
      chk("swap/out_valid", 32'(out_valid), 32'd1);
      chk("swap/result", result, 32'h000F_000F);
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;

      // ---- flush during DIVU ----
      @(negedge clk);
      drive(2'b10, 3'b101, 1'b0, 1'b1, 32'd1000, 32'd7);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush/in_ready", 32'(in_ready), 32'd1);
      seen = out_valid;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1 seen = seen | out_valid;
      end
      $display("flush: out_valid seen=%b in_ready=%b", seen, in_ready);
      chk("flush/no_result", 32'(seen), 32'd0);

      // ---- asynchronous reset mid-MUL ----
      @(negedge clk);
      drive(2'b10, 3'b000, 1'b0, 1'b1, 32'd12345, 32'd678);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset: out_valid=%b in_ready=%b result=%h zero=%b", out_valid, in_ready, result, zero);
      chk("areset/out_valid", 32'(out_valid), 32'd0);
      chk("areset/in_ready", 32'(in_ready), 32'd1);
      chk("areset/result", result, 32'd0);
      chk("areset/zero", 32'(zero), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      run_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, "add_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
